// File: rtl/scc_mem_pkg.sv
// Shared types and helpers for the SCC memory subsystem.
// Latency: n/a (package). Backpressure: n/a.
// Optional feature macro used by this block: SCC_MEM_CLEAR_EN.
package scc_mem_pkg;

    localparam int DATA_W        = 32;
    localparam int DEFAULT_DEPTH = 1024;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Misaligned, or beyond the last word of an array with 2**aw words.
    function automatic logic addr_illegal(input logic [31:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/scc_mem_array.sv
// DEPTH x 32 word array: two asynchronous read ports (fetch, data), one write port.
// Latency: reads combinational, write lands on the next rising edge.
// Backpressure: none; every write request is committed. Contents are never reset.
module scc_mem_array
    import scc_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [AW-1:0]     if_addr,
    output logic [DATA_W-1:0] if_dat,
    input  logic [AW-1:0]     dm_addr,
    output logic [DATA_W-1:0] dm_dat
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign if_dat = mem[if_addr];
    assign dm_dat = mem[dm_addr];

endmodule

// File: rtl/scc_mem_sys.sv
// SCC core memory responder: streaming loader, optional zero-fill (SCC_MEM_CLEAR_EN), then core port.
// Latency: core reads combinational, writes one edge; one load word per cycle.
// Backpressure: ld_ready high only in LOAD; core is held via core_hold until RUN.
module scc_mem_sys
    import scc_mem_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_s,
    input  logic [31:0]       in_mem_addr,
    input  logic              in_mem_en,
    output logic [31:0]       in_mem,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_out,
    input  logic              data_read,
    input  logic              data_write,
    output logic [31:0]       data_in,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              core_hold,
    output logic [AW:0]       ld_count,
    output logic              fault
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    state_t            state;
    logic [AW:0]       ptr;
    logic              run;
    logic              if_ill;
    logic              dm_ill;
    logic              dm_acc;
    logic              ld_acc;
    logic              core_we;
    logic              arr_we;
    logic [AW-1:0]     arr_addr;
    logic [DATA_W-1:0] arr_dat;
    logic [DATA_W-1:0] if_dat;
    logic [DATA_W-1:0] dm_dat;

    assign ld_ready  = (state == ST_LOAD);
    assign core_hold = (state != ST_RUN);

    always_comb begin
        run      = (state == ST_RUN);
        if_ill   = addr_illegal(in_mem_addr, AW);
        dm_ill   = addr_illegal(data_addr, AW);
        dm_acc   = data_read | data_write;
        ld_acc   = ld_valid & ld_ready;
        core_we  = run & data_write & ~dm_ill;
        // The loader owns the write port until RUN; afterwards only the core writes.
        arr_we   = ld_acc | (state == ST_CLEAR) | core_we;
        arr_addr = run ? data_addr[AW+1:2] : ptr[AW-1:0];
        arr_dat  = run ? data_out : ((state == ST_LOAD) ? ld_data : '0);
        in_mem   = (run & in_mem_en & ~if_ill) ? if_dat : '0;
        data_in  = (run & dm_acc & ~dm_ill) ? dm_dat : '0;
    end

    always_ff @(posedge clk or negedge reset_s) begin
        if (!reset_s) begin
            state    <= ST_LOAD;
            ptr      <= '0;
            ld_count <= '0;
            fault    <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (ld_valid) begin
                        ptr      <= ptr + 1'b1;
                        ld_count <= ld_count + 1'b1;
                        if (ld_last || ptr == LAST_IDX) begin
`ifdef SCC_MEM_CLEAR_EN
                            // A full load leaves nothing to clear.
                            state <= (ptr == LAST_IDX) ? ST_RUN : ST_CLEAR;
`else
                            state <= ST_RUN;
`endif
                        end
                    end
                end
                ST_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_IDX) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((in_mem_en & if_ill) | (dm_acc & dm_ill)) begin
                        fault <= 1'b1;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    scc_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_we),
        .wr_addr (arr_addr),
        .wr_dat  (arr_dat),
        .if_addr (in_mem_addr[AW+1:2]),
        .if_dat  (if_dat),
        .dm_addr (data_addr[AW+1:2]),
        .dm_dat  (dm_dat)
    );

endmodule

// File: tb/tb_scc_mem_sys.sv
// Directed plus randomized checks of scc_mem_sys against a word-array reference model.
// Works with and without SCC_MEM_CLEAR_EN.
`timescale 1ns/1ps
module tb_scc_mem_sys;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
`ifdef SCC_MEM_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_s;
    logic [31:0] in_mem_addr;
    logic        in_mem_en;
    logic [31:0] in_mem;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_in;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        core_hold;
    logic [AW:0] ld_count;
    logic        fault;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] mem_m [DEPTH];
    int          ld_ptr = 0;
    logic        m_fault = 1'b0;

    always #5 clk = ~clk;

    scc_mem_sys #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_s     (reset_s),
        .in_mem_addr (in_mem_addr),
        .in_mem_en   (in_mem_en),
        .in_mem      (in_mem),
        .data_addr   (data_addr),
        .data_out    (data_out),
        .data_read   (data_read),
        .data_write  (data_write),
        .data_in     (data_in),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .core_hold   (core_hold),
        .ld_count    (ld_count),
        .fault       (fault)
    );

    function automatic bit ill(input logic [31:0] a);
        return ((a % 32'd4) != 32'd0) || (a >= 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input bit en);
        if (!en || ill(a)) return 32'd0;
        return mem_m[int'(a >> 2)];
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        int r;
        r = int'($urandom_range(0, 15));
        a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
        if (r == 0) a = $urandom;
        else if (r == 1) a = a | 32'($urandom_range(1, 3));
        else if (r == 2) a = a + 32'(DEPTH * 4);
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_core();
        in_mem_en  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    task automatic do_reset();
        reset_s     = 1'b0;
        in_mem_en   = 1'b1;
        in_mem_addr = 32'h0;
        data_read   = 1'b1;
        data_addr   = 32'h0;
        #1;
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_core_hold", 32'(core_hold), 32'd1);
        chk("rst_ld_count", 32'(ld_count), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_in_mem", in_mem, 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        idle_core();
        #1;
        reset_s = 1'b1;
        ld_ptr  = 0;
        m_fault = 1'b0;
    endtask

    // Streams n words; the core keeps poking the port, which must have no effect before RUN.
    task automatic load_stream(input int n, input bit use_last, input int kind);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            if (kind == 0)      w = 32'h11 * 32'(i + 1);
            else if (kind == 1) w = 32'hFFFF_FFFF;
            else                w = $urandom;
            ld_valid    = 1'b1;
            ld_data     = w;
            ld_last     = use_last && (i == n - 1);
            in_mem_en   = 1'b1;
            in_mem_addr = 32'h6;
            data_read   = 1'b1;
            data_write  = 1'b1;
            data_addr   = 32'h3C;
            data_out    = 32'h5A5A_5A5A;
            #1;
            chk("load_ld_ready", 32'(ld_ready), 32'd1);
            chk("load_in_mem", in_mem, 32'd0);
            chk("load_data_in", data_in, 32'd0);
            tick();
            mem_m[ld_ptr] = w;
            ld_ptr++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        idle_core();
    endtask

    task automatic finish_load();
        int cycles;
        int exp_hold;
        chk("ld_count", 32'(ld_count), 32'(ld_ptr));
        exp_hold = (CLEAR_EN && ld_ptr < DEPTH) ? DEPTH - ld_ptr : 0;
        cycles = 0;
        while (core_hold === 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        chk("hold_cycles", 32'(cycles), 32'(exp_hold));
        chk("run_ld_ready", 32'(ld_ready), 32'd0);
        chk("run_fault", 32'(fault), 32'd0);
        if (CLEAR_EN) begin
            for (int i = ld_ptr; i < DEPTH; i++) mem_m[i] = 32'd0;
        end
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a);
        in_mem_en   = 1'b1;
        in_mem_addr = a;
        data_read   = 1'b1;
        data_write  = 1'b0;
        data_addr   = a;
        #1;
        chk({tag, "_if"}, in_mem, exp_rd(a, 1'b1));
        chk({tag, "_dm"}, data_in, exp_rd(a, 1'b1));
        idle_core();
    endtask

    initial begin
        logic [31:0] fa, da, dout, e_if, e_dm;
        bit en, rd, wr;

        reset_s = 1'b0;
        in_mem_addr = '0; data_addr = '0; data_out = '0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        idle_core();
        tick();
        tick();
        do_reset();

        // Full-depth load without ld_last: exits on the last word, no clear phase.
        load_stream(DEPTH, 1'b0, 1);
        finish_load();
        ld_valid = 1'b1;
        tick();
        chk("run_ignores_ld_ready", 32'(ld_ready), 32'd0);
        chk("run_ignores_ld_count", 32'(ld_count), 32'(DEPTH));
        ld_valid = 1'b0;
        rd_check("full_top", 32'h3C);

        // Reset mid-load: counters clear at once, array data survives.
        do_reset();
        load_stream(3, 1'b0, 2);
        do_reset();
        load_stream(1, 1'b1, 2);
        finish_load();
        rd_check("reload_w0", 32'h0);
        rd_check("reload_w1", 32'h4);

        // Four-word load with ld_last.
        do_reset();
        load_stream(4, 1'b1, 0);
        finish_load();
        rd_check("four_w2", 32'h8);
        chk("four_w2_lit", exp_rd(32'h8, 1'b1), 32'h33);
        rd_check("four_top", 32'h3C);

        // Two-word load: clear phase length and top word.
        do_reset();
        load_stream(2, 1'b1, 2);
        finish_load();
        rd_check("two_top", 32'h3C);
        rd_check("two_w4", 32'h10);

        // Read+write together, with a fetch of the same word: both see the old word.
        in_mem_en = 1'b1; in_mem_addr = 32'h10;
        data_read = 1'b1; data_write = 1'b1; data_addr = 32'h10; data_out = 32'hDEAD_BEEF;
        #1;
        chk("rw_old_dm", data_in, mem_m[4]);
        chk("rw_old_if", in_mem, mem_m[4]);
        tick();
        mem_m[4] = 32'hDEAD_BEEF;
        idle_core();
        rd_check("rw_new", 32'h10);
        chk("rw_fault", 32'(fault), 32'd0);

        // Illegal fetch and data read return 0 and set a sticky fault.
        in_mem_en = 1'b1; in_mem_addr = 32'h6;
        data_read = 1'b1; data_addr = 32'h1000;
        #1;
        chk("ill_if", in_mem, 32'd0);
        chk("ill_dm", data_in, 32'd0);
        chk("ill_fault_pre", 32'(fault), 32'd0);
        tick();
        chk("ill_fault_post", 32'(fault), 32'd1);
        // Out-of-range writes alias word 0 in the index bits and must be dropped.
        in_mem_en = 1'b0; data_read = 1'b0;
        data_write = 1'b1; data_addr = 32'h40; data_out = 32'h1234_5678;
        tick();
        data_addr = 32'h42;
        tick();
        idle_core();
        rd_check("ill_wr_dropped", 32'h0);
        tick();
        chk("fault_sticky", 32'(fault), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        load_stream(5, 1'b1, 2);
        finish_load();
        for (int k = 0; k < 200; k++) begin
            en   = 1'($urandom_range(0, 1));
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            fa   = pick_addr();
            da   = pick_addr();
            dout = $urandom;
            in_mem_en = en; in_mem_addr = fa;
            data_read = rd; data_write = wr; data_addr = da; data_out = dout;
            e_if = exp_rd(fa, en);
            e_dm = exp_rd(da, rd || wr);
            #1;
            chk("rnd_if", in_mem, e_if);
            chk("rnd_dm", data_in, e_dm);
            tick();
            if (wr && !ill(da)) mem_m[int'(da >> 2)] = dout;
            if ((en && ill(fa)) || ((rd || wr) && ill(da))) m_fault = 1'b1;
            chk("rnd_fault", 32'(fault), 32'(m_fault));
        end
        idle_core();
        for (int i = 0; i < DEPTH; i++) rd_check("final_sweep", 32'(i * 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
